// File: rtl/ecall_halt_stat_unit_if.sv
// Decoder-side and status-side signals of the ecall/halt/statistics unit.
// The master drives decoder strobes and register values; the slave returns status and counters.
interface ecall_halt_stat_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ecall;
  logic             jal;
  logic             jalr;
  logic             BEQ;
  logic             BNE;
  logic             blt;
  logic             br_taken;
  logic [WIDTH-1:0] a7;
  logic [WIDTH-1:0] a0;
  logic             go;
  logic             pc_en;
  logic             halt;
  logic [WIDTH-1:0] led_data;
  logic [WIDTH-1:0] total_cycles;
  logic [WIDTH-1:0] uncond_jumps;
  logic [WIDTH-1:0] cond_taken;

  modport master (
    output ecall, jal, jalr, BEQ, BNE, blt, br_taken, a7, a0, go,
    input  pc_en, halt, led_data, total_cycles, uncond_jumps, cond_taken
  );

  modport slave (
    input  ecall, jal, jalr, BEQ, BNE, blt, br_taken, a7, a0, go,
    output pc_en, halt, led_data, total_cycles, uncond_jumps, cond_taken
  );
endinterface

// File: rtl/ecall_halt_stat_unit.sv
// ecall services (LED display, halt) with go-button resume, PC gating and run statistics.
// The FSM state is the registered halt bit.
module ecall_halt_stat_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DISP_CODE = 34,
  parameter int unsigned HALT_CODE = 10
) (
  input logic                  clk,
  input logic                  rst,
  ecall_halt_stat_unit_if.slave bus
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DISP_VAL  = WIDTH'(DISP_CODE);
  localparam logic [WIDTH-1:0] HALT_VAL  = WIDTH'(HALT_CODE);

  logic [0:0]       state_q, state_d;
  logic             go_q, go_d;
  logic [WIDTH-1:0] led_data_q, led_data_d;
  logic [WIDTH-1:0] total_cycles_q, total_cycles_d;
  logic [WIDTH-1:0] uncond_jumps_q, uncond_jumps_d;
  logic [WIDTH-1:0] cond_taken_q, cond_taken_d;

  logic running;
  logic go_rise;

  always_comb begin
    running        = (state_q == RUN);
    go_rise        = bus.go & ~go_q;
    go_d           = bus.go;
    state_d        = state_q;
    led_data_d     = led_data_q;
    total_cycles_d = total_cycles_q;
    uncond_jumps_d = uncond_jumps_q;
    cond_taken_d   = cond_taken_q;

    if (running) begin
      total_cycles_d = total_cycles_q + ONE;
      if (bus.jal | bus.jalr)
        uncond_jumps_d = uncond_jumps_q + ONE;
      if ((bus.BEQ | bus.BNE | bus.blt) & bus.br_taken)
        cond_taken_d = cond_taken_q + ONE;
      if (bus.ecall && bus.a7 == DISP_VAL)
        led_data_d = bus.a0;
      if (bus.ecall && bus.a7 == HALT_VAL)
        state_d = HALT;
    end else if (go_rise) begin
      // Only a fresh go edge resumes; a level held across the halt was already sampled into go_q.
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      go_q           <= 1'b0;
      led_data_q     <= '0;
      total_cycles_q <= '0;
      uncond_jumps_q <= '0;
      cond_taken_q   <= '0;
    end else begin
      state_q        <= state_d;
      go_q           <= go_d;
      led_data_q     <= led_data_d;
      total_cycles_q <= total_cycles_d;
      uncond_jumps_q <= uncond_jumps_d;
      cond_taken_q   <= cond_taken_d;
    end
  end

  assign bus.pc_en        = (state_q == RUN);
  assign bus.halt         = state_q[0];
  assign bus.led_data     = led_data_q;
  assign bus.total_cycles = total_cycles_q;
  assign bus.uncond_jumps = uncond_jumps_q;
  assign bus.cond_taken   = cond_taken_q;
endmodule

// File: tb/tb_ecall_halt_stat_unit.sv
// Directed self-checking bench for ecall_halt_stat_unit.
// A 4-bit instance is used alongside the 32-bit one to reach counter wrap quickly.
module tb_ecall_halt_stat_unit;
  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  ecall_halt_stat_unit_if #(.WIDTH(32)) bus ();
  ecall_halt_stat_unit_if #(.WIDTH(4))  sbus ();

  ecall_halt_stat_unit #(.WIDTH(32), .DISP_CODE(34), .HALT_CODE(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ecall_halt_stat_unit #(.WIDTH(4), .DISP_CODE(3), .HALT_CODE(10)) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (sbus)
  );

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.ecall = 0; bus.jal = 0; bus.jalr = 0; bus.BEQ = 0; bus.BNE = 0;
    bus.blt = 0; bus.br_taken = 0; bus.a7 = '0; bus.a0 = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int unsigned i = 0; i < 2; i++) begin
      bus.ecall = 1'($urandom); bus.jal = 1'($urandom); bus.jalr = 1'($urandom);
      bus.BEQ = 1'($urandom); bus.BNE = 1'($urandom); bus.blt = 1'($urandom);
      bus.br_taken = 1'($urandom); bus.a7 = $urandom; bus.a0 = $urandom;
      bus.go = 1'($urandom);
      tick();
    end
    rst = 0;
    idle();
    bus.go = 0;
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%0b exp=0", bus.halt); end
    total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL reset_pc_en got=%0b exp=1", bus.pc_en); end
    total++; if (bus.led_data !== 32'h0) begin bad++; $display("FAIL reset_led got=%h exp=0", bus.led_data); end
    total++; if (bus.total_cycles !== 32'h0) begin bad++; $display("FAIL reset_total got=%0d exp=0", bus.total_cycles); end
    total++; if (bus.uncond_jumps !== 32'h0) begin bad++; $display("FAIL reset_uj got=%0d exp=0", bus.uncond_jumps); end
    total++; if (bus.cond_taken !== 32'h0) begin bad++; $display("FAIL reset_ct got=%0d exp=0", bus.cond_taken); end
  endtask

  task automatic test_display();
    bus.a7 = 32'd34; bus.a0 = 32'h0000_00AB; bus.ecall = 1;
    tick();
    idle();
    total++; if (bus.led_data !== 32'h0000_00AB) begin bad++; $display("FAIL disp_led got=%h exp=000000ab", bus.led_data); end
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL disp_halt got=%0b exp=0", bus.halt); end
    total++; if (bus.total_cycles !== 32'd1) begin bad++; $display("FAIL disp_total1 got=%0d exp=1", bus.total_cycles); end
    tick(2);
    total++; if (bus.total_cycles !== 32'd3) begin bad++; $display("FAIL disp_total3 got=%0d exp=3", bus.total_cycles); end
    total++; if (bus.led_data !== 32'h0000_00AB) begin bad++; $display("FAIL disp_hold got=%h exp=000000ab", bus.led_data); end
  endtask

  task automatic test_halt_resume();
    bus.a7 = 32'd10; bus.ecall = 1;
    #1;
    total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL halt_ecall_pc_en got=%0b exp=1", bus.pc_en); end
    tick();
    idle();
    total++; if (bus.halt !== 1'b1) begin bad++; $display("FAIL halt_rise got=%0b exp=1", bus.halt); end
    total++; if (bus.pc_en !== 1'b0) begin bad++; $display("FAIL halt_pc_en got=%0b exp=0", bus.pc_en); end
    total++; if (bus.total_cycles !== 32'd4) begin bad++; $display("FAIL halt_total got=%0d exp=4", bus.total_cycles); end
    // Strobes and a display ecall while halted must all be ignored.
    bus.jal = 1; bus.BEQ = 1; bus.br_taken = 1; bus.ecall = 1; bus.a7 = 32'd34; bus.a0 = 32'h55;
    tick(5);
    idle();
    total++; if (bus.total_cycles !== 32'd4) begin bad++; $display("FAIL halted_total got=%0d exp=4", bus.total_cycles); end
    total++; if (bus.uncond_jumps !== 32'd0) begin bad++; $display("FAIL halted_uj got=%0d exp=0", bus.uncond_jumps); end
    total++; if (bus.cond_taken !== 32'd0) begin bad++; $display("FAIL halted_ct got=%0d exp=0", bus.cond_taken); end
    total++; if (bus.led_data !== 32'h0000_00AB) begin bad++; $display("FAIL halted_led got=%h exp=000000ab", bus.led_data); end
    total++; if (bus.halt !== 1'b1) begin bad++; $display("FAIL halted_stay got=%0b exp=1", bus.halt); end
    bus.go = 1;
    tick();
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL resume_halt got=%0b exp=0", bus.halt); end
    total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL resume_pc_en got=%0b exp=1", bus.pc_en); end
    total++; if (bus.total_cycles !== 32'd4) begin bad++; $display("FAIL resume_total got=%0d exp=4", bus.total_cycles); end
    bus.go = 0;
    tick();
    total++; if (bus.total_cycles !== 32'd5) begin bad++; $display("FAIL run_total got=%0d exp=5", bus.total_cycles); end
  endtask

  task automatic test_held_go();
    bus.go = 1;
    tick();
    bus.a7 = 32'd10; bus.ecall = 1;
    tick();
    idle();
    tick(3);
    total++; if (bus.halt !== 1'b1) begin bad++; $display("FAIL heldgo_halt got=%0b exp=1", bus.halt); end
    total++; if (bus.total_cycles !== 32'd7) begin bad++; $display("FAIL heldgo_total got=%0d exp=7", bus.total_cycles); end
    bus.go = 0;
    tick();
    total++; if (bus.halt !== 1'b1) begin bad++; $display("FAIL heldgo_drop got=%0b exp=1", bus.halt); end
    bus.go = 1;
    tick();
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL heldgo_resume got=%0b exp=0", bus.halt); end
    bus.go = 0;
  endtask

  task automatic test_counting();
    bus.jal = 1; tick(3); bus.jal = 0;
    bus.jalr = 1; tick(2); bus.jalr = 0;
    total++; if (bus.uncond_jumps !== 32'd5) begin bad++; $display("FAIL count_uj got=%0d exp=5", bus.uncond_jumps); end
    bus.BEQ = 1; bus.br_taken = 1; tick(); bus.BEQ = 0;
    bus.BNE = 1; bus.br_taken = 0; tick(); bus.BNE = 0;
    bus.blt = 1; bus.br_taken = 1; tick(); bus.blt = 0;
    tick();
    bus.br_taken = 0;
    total++; if (bus.cond_taken !== 32'd2) begin bad++; $display("FAIL count_ct got=%0d exp=2", bus.cond_taken); end
    total++; if (bus.total_cycles !== 32'd16) begin bad++; $display("FAIL count_total got=%0d exp=16", bus.total_cycles); end
    bus.jal = 1; bus.BEQ = 1; bus.br_taken = 1;
    tick();
    idle();
    total++; if (bus.uncond_jumps !== 32'd6) begin bad++; $display("FAIL simul_uj got=%0d exp=6", bus.uncond_jumps); end
    total++; if (bus.cond_taken !== 32'd3) begin bad++; $display("FAIL simul_ct got=%0d exp=3", bus.cond_taken); end
    bus.ecall = 1; bus.a7 = 32'd5; bus.a0 = 32'h77;
    tick();
    idle();
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL unk_ecall_halt got=%0b exp=0", bus.halt); end
    total++; if (bus.led_data !== 32'h0000_00AB) begin bad++; $display("FAIL unk_ecall_led got=%h exp=000000ab", bus.led_data); end
    total++; if (bus.total_cycles !== 32'd18) begin bad++; $display("FAIL unk_ecall_total got=%0d exp=18", bus.total_cycles); end
  endtask

  task automatic test_wrap();
    rst_s = 1;
    tick();
    rst_s = 0;
    sbus.jal = 1; sbus.blt = 1; sbus.br_taken = 1;
    tick(15);
    total++; if (sbus.total_cycles !== 4'd15) begin bad++; $display("FAIL wrap_pre_total got=%0d exp=15", sbus.total_cycles); end
    tick();
    total++; if (sbus.total_cycles !== 4'd0) begin bad++; $display("FAIL wrap_total got=%0d exp=0", sbus.total_cycles); end
    total++; if (sbus.uncond_jumps !== 4'd0) begin bad++; $display("FAIL wrap_uj got=%0d exp=0", sbus.uncond_jumps); end
    total++; if (sbus.cond_taken !== 4'd0) begin bad++; $display("FAIL wrap_ct got=%0d exp=0", sbus.cond_taken); end
    tick();
    total++; if (sbus.total_cycles !== 4'd1) begin bad++; $display("FAIL wrap_post_total got=%0d exp=1", sbus.total_cycles); end
    sbus.jal = 0; sbus.blt = 0; sbus.br_taken = 0;
  endtask

  task automatic test_reset_mid_halt();
    bus.a7 = 32'd10; bus.ecall = 1;
    tick();
    idle();
    total++; if (bus.halt !== 1'b1) begin bad++; $display("FAIL midhalt_pre got=%0b exp=1", bus.halt); end
    rst = 1;
    tick();
    rst = 0;
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL midhalt_halt got=%0b exp=0", bus.halt); end
    total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL midhalt_pc_en got=%0b exp=1", bus.pc_en); end
    total++; if (bus.total_cycles !== 32'd0) begin bad++; $display("FAIL midhalt_total got=%0d exp=0", bus.total_cycles); end
    total++; if (bus.uncond_jumps !== 32'd0) begin bad++; $display("FAIL midhalt_uj got=%0d exp=0", bus.uncond_jumps); end
    total++; if (bus.cond_taken !== 32'd0) begin bad++; $display("FAIL midhalt_ct got=%0d exp=0", bus.cond_taken); end
    total++; if (bus.led_data !== 32'd0) begin bad++; $display("FAIL midhalt_led got=%h exp=0", bus.led_data); end
  endtask

  initial begin
    rst = 1; rst_s = 1;
    idle();
    bus.go = 0;
    sbus.ecall = 0; sbus.jal = 0; sbus.jalr = 0; sbus.BEQ = 0; sbus.BNE = 0;
    sbus.blt = 0; sbus.br_taken = 0; sbus.a7 = '0; sbus.a0 = '0; sbus.go = 0;
    #1;
    test_reset();
    test_display();
    test_halt_resume();
    test_held_go();
    test_counting();
    test_wrap();
    test_reset_mid_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ecall_halt_stat_unit.md
Name: ecall_halt_stat_unit

Overview:
- Sits directly downstream of the control signal decoder in the single-cycle RISC-V core.
- Consumes the decoder's ecall, jal, jalr, BEQ, BNE and blt strobes, plus the register-file values of a7 (x17) and a0 (x10).
- Implements ecall services: display a0 on the LED bus, or halt the core.
- Gates PC advance while halted and maintains the run-statistics counters shown on the board display.

Parameters:
- WIDTH, 32: width of a0/a7, the LED bus and every counter.
- DISP_CODE, 34: a7 value selecting the "display a0" service.
- HALT_CODE, 10: a7 value selecting the "halt" service.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ecall  in  1  decoder strobe: the current instruction is ecall.
- jal  in  1  decoder strobe: the current instruction is jal.
- jalr  in  1  decoder strobe: the current instruction is jalr.
- BEQ  in  1  decoder strobe: the current instruction is beq.
- BNE  in  1  decoder strobe: the current instruction is bne.
- blt  in  1  decoder strobe: the current instruction is blt.
- br_taken  in  1  the branch condition of the current instruction evaluated true (from the ALU compare).
- a7  in  WIDTH  register-file read of x17.
- a0  in  WIDTH  register-file read of x10.
- go  in  1  resume button, already debounced and synchronised to clk.
- pc_en  out  1  PC register write enable.
- halt  out  1  core is halted.
- led_data  out  WIDTH  last value displayed by ecall.
- total_cycles  out  WIDTH  cycles spent running.
- uncond_jumps  out  WIDTH  count of jal/jalr executed.
- cond_taken  out  WIDTH  count of beq/bne/blt taken.

Behaviour:
- One clock domain (clk); rst is synchronous and active-high. rst has priority over every other input in any state, including mid-halt.
- Reset values: state=RUN, halt=0, led_data=0, all counters=0, go_q=0. pc_en therefore reads 1 in the cycle after reset.
- State machine, 2 states, encoded in the registered halt bit:
  - RUN (halt=0): pc_en=1, combinational from state only.
  - HALT (halt=1): pc_en=0.
- RUN -> HALT: on the edge where ecall=1 and a7==HALT_CODE.
  - The halting ecall's own cycle still has pc_en=1, so the PC moves past the ecall.
  - halt rises on that same edge.
- HALT -> RUN: on the edge where (go & ~go_q)=1, i.e. a rising edge of go.
  - go_q is a register sampling go every cycle, in both states.
  - A go level held since before the halt does not resume; only a fresh rising edge does.
  - go activity during RUN has no effect.
- Display service: in RUN, ecall=1 with a7==DISP_CODE loads led_data<=a0 on that edge. led_data holds until the next display ecall or rst.
- Unrecognised ecall: ecall=1 with any other a7 is a no-op (PC advances, no state change).
- Counters advance only in RUN, and only in cycles where pc_en=1:
  - total_cycles increments every RUN cycle, including the halting ecall cycle. It is frozen throughout HALT.
  - uncond_jumps increments when (jal | jalr)=1.
  - cond_taken increments when (BEQ | BNE | blt) & br_taken = 1. br_taken is ignored when no branch strobe is active.
- All counters wrap modulo 2^WIDTH with no saturation or flag.
- Simultaneous strobes: each counter evaluates its own term independently. Strobes from the decoder are one-hot, but the block does not rely on it.
- While in HALT, every decoder strobe, a0, a7 and br_taken is ignored: no counter, LED or state update except the go edge or rst.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> halt=0, pc_en=1, led_data=0 and all counters 0 on the first cycle after release.
- Display: a7=34, a0=0x0000_00AB, ecall pulse 1 cycle -> led_data=0xAB on the next edge; halt stays 0; total_cycles advances by 1 per cycle.
- Halt and resume:
  - a7=10, ecall pulse -> pc_en=1 in that cycle, halt=1 and pc_en=0 from the next edge.
  - Hold for 5 cycles with jal=1 -> total_cycles and uncond_jumps unchanged.
  - go 0->1 -> halt=0 one edge later.
- Held go: go=1 held before and during a halt ecall -> core stays halted. Drop go, then raise it -> resume.
- Counting:
  - 3 jal, 2 jalr -> uncond_jumps=5.
  - beq with br_taken=1, bne with br_taken=0, blt with br_taken=1 -> cond_taken=2.
  - br_taken=1 with no branch strobe -> no change.
- Wrap and reset mid-halt:
  - Preload counters to 0xFFFF_FFFF by forcing state, run 1 cycle -> total_cycles=0.
  - Assert rst while halt=1 -> RUN with counters cleared on the next edge.
